// File: rtl/rr_arbiter8.sv
// Eight-client round-robin arbiter with hold timeout.
// Grants one client at a time; the client just served drops to lowest priority.
module rr_arbiter8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam int unsigned N  = 8;
  localparam int unsigned IW = 3;
  localparam int unsigned CW = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   ptr_d;
  logic [CW-1:0]   hold_cnt_q;
  logic [CW-1:0]   hold_cnt_d;
  logic [N-1:0]    gnt_d;
  logic            gnt_valid_d;
  logic            timeout_d;

  logic [N-1:0]    rot_c;
  logic [IW-1:0]   off_c;
  logic [IW-1:0]   pick_idx_c;
  logic            pick_any_c;
  logic [IW-1:0]   cur_idx_c;
  logic            hold_hit_c;

  // Rotate the request vector so bit 0 is the client at ptr.
  always_comb begin
    rot_c = '0;
    for (int i = 0; i < int'(N); i++) begin
      rot_c[i] = req[IW'(ptr_q + IW'(i))];
    end
  end

  // Lowest set bit of the rotated vector, mapped back to a client index.
  always_comb begin
    logic found;
    off_c = '0;
    found = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (rot_c[i] && !found) begin
        off_c = IW'(i);
        found = 1'b1;
      end
    end
    pick_any_c = |req;
    pick_idx_c = IW'(ptr_q + off_c);
  end

  // Binary index of the currently held one-hot grant.
  always_comb begin
    cur_idx_c = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (gnt[i]) begin
        cur_idx_c = IW'(i);
      end
    end
  end

  assign hold_hit_c = (MAX_HOLD != 0) && (hold_cnt_q == CW'(MAX_HOLD));
  assign gnt_idx    = gnt_valid ? cur_idx_c : 3'bzzz;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      gnt        <= '0;
      gnt_valid  <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      gnt        <= gnt_d;
      gnt_valid  <= gnt_valid_d;
      timeout    <= timeout_d;
    end
  end

  // Next state, rotation pointer and hold counter.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    unique case (state_q)
      IDLE: begin
        hold_cnt_d = '0;
        if (pick_any_c) begin
          state_d    = GRANT;
          hold_cnt_d = CW'(1);
        end
      end
      GRANT: begin
        if (done || hold_hit_c) begin
          state_d    = IDLE;
          ptr_d      = IW'(cur_idx_c + IW'(1));
          hold_cnt_d = '0;
        end else if (hold_cnt_q != {CW{1'b1}}) begin
          hold_cnt_d = CW'(hold_cnt_q + CW'(1));
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    gnt_d       = '0;
    gnt_valid_d = 1'b0;
    timeout_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_any_c) begin
          gnt_d       = N'(1) << pick_idx_c;
          gnt_valid_d = 1'b1;
        end
      end
      GRANT: begin
        if (done) begin
          timeout_d = 1'b0;
        end else if (hold_hit_c) begin
          timeout_d = 1'b1;
        end else begin
          gnt_d       = gnt;
          gnt_valid_d = 1'b1;
        end
      end
      default: begin
        gnt_d = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: directed table, corner sequences and random traffic
// against a client-level reference model, on three MAX_HOLD settings.
module tb_rr_arbiter8;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       done;

  logic [7:0] gnt_a, gnt_b, gnt_c;
  wire  [2:0] idx_a, idx_b, idx_c;
  logic       val_a, val_b, val_c;
  logic       to_a, to_b, to_c;

  int total;
  int bad;

  rr_arbiter8 #(.MAX_HOLD(4)) u_a (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt_a), .gnt_idx(idx_a), .gnt_valid(val_a), .timeout(to_a));

  rr_arbiter8 #(.MAX_HOLD(3)) u_b (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt_b), .gnt_idx(idx_b), .gnt_valid(val_b), .timeout(to_b));

  rr_arbiter8 #(.MAX_HOLD(0)) u_c (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt_c), .gnt_idx(idx_c), .gnt_valid(val_c), .timeout(to_c));

  always #5 clk = ~clk;

  // Reference model: who owns the resource, for how long, and who is next.
  int m_max   [3];
  int m_owner [3];
  int m_held  [3];
  int m_ptr   [3];
  bit m_to    [3];
  bit prev_to [3];

  typedef struct {
    logic       r;
    logic [7:0] q;
    logic       d;
    logic [7:0] eg;
    logic       ev;
    logic       et;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic [7:0] q, logic d,
                              logic [7:0] eg, logic ev, logic et);
    vec_t v;
    v.r = r; v.q = q; v.d = d; v.eg = eg; v.ev = ev; v.et = et;
    return v;
  endfunction

  function automatic int oh_idx(logic [7:0] g);
    int r;
    r = 0;
    for (int i = 0; i < 8; i++) if (g[i]) r = i;
    return r;
  endfunction

  task automatic cmp(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic [7:0] q, input logic d);
    for (int k = 0; k < 3; k++) begin
      if (r) begin
        m_owner[k] = -1; m_held[k] = 0; m_ptr[k] = 0; m_to[k] = 0;
      end else if (m_owner[k] < 0) begin
        m_to[k] = 0;
        for (int j = 0; j < 8; j++) begin
          int c;
          c = (m_ptr[k] + j) % 8;
          if (m_owner[k] < 0 && q[3'(c)]) begin
            m_owner[k] = c;
            m_held[k]  = 1;
          end
        end
      end else if (d || (m_max[k] != 0 && m_held[k] == m_max[k])) begin
        m_to[k]    = !d;
        m_ptr[k]   = (m_owner[k] + 1) % 8;
        m_owner[k] = -1;
        m_held[k]  = 0;
      end else begin
        m_held[k] = (m_held[k] < 255) ? m_held[k] + 1 : 255;
        m_to[k]   = 0;
      end
    end
  endtask

  task automatic check_dut(input int k, input logic [7:0] g, input logic [2:0] ix,
                           input logic v, input logic t);
    logic [7:0] eg;
    eg = (m_owner[k] < 0) ? 8'h00 : 8'(1 << m_owner[k]);
    cmp($sformatf("dut%0d gnt", k), int'(g), int'(eg));
    cmp($sformatf("dut%0d gnt_valid", k), int'(v), int'(m_owner[k] >= 0));
    cmp($sformatf("dut%0d timeout", k), int'(t), int'(m_to[k]));
    if (v === 1'b1) cmp($sformatf("dut%0d gnt_idx", k), int'(ix), oh_idx(g));
    cmp($sformatf("dut%0d onehot", k), int'($countones(g) <= 1), 1);
    cmp($sformatf("dut%0d valid_eq_or", k), int'(v), int'(|g));
    cmp($sformatf("dut%0d timeout_twice", k), int'(t && prev_to[k]), 0);
    prev_to[k] = t;
  endtask

  task automatic step(input logic r, input logic [7:0] q, input logic d);
    rst = r; req = q; done = d;
    @(posedge clk);
    model_step(r, q, d);
    @(negedge clk);
    check_dut(0, gnt_a, idx_a, val_a, to_a);
    check_dut(1, gnt_b, idx_b, val_b, to_b);
    check_dut(2, gnt_c, idx_c, val_c, to_c);
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; req = '0; done = 1'b0;
    total = 0; bad = 0;
    m_max = '{4, 3, 0};
    for (int k = 0; k < 3; k++) begin
      m_owner[k] = -1; m_held[k] = 0; m_ptr[k] = 0; m_to[k] = 0; prev_to[k] = 0;
    end

    // Expected values for the MAX_HOLD=4 instance.
    tbl.push_back(mk(1, 8'h00, 0, 8'h00, 0, 0));
    tbl.push_back(mk(1, 8'h00, 0, 8'h00, 0, 0));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 8'h00, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 8'h20, 0, 8'h20, 1, 0));
    tbl.push_back(mk(0, 8'h20, 0, 8'h20, 1, 0));
    tbl.push_back(mk(0, 8'h20, 0, 8'h20, 1, 0));
    tbl.push_back(mk(0, 8'h20, 1, 8'h00, 0, 0));
    tbl.push_back(mk(0, 8'h21, 0, 8'h01, 1, 0));
    tbl.push_back(mk(0, 8'h21, 1, 8'h00, 0, 0));
    tbl.push_back(mk(0, 8'h08, 0, 8'h08, 1, 0));
    tbl.push_back(mk(0, 8'h08, 0, 8'h08, 1, 0));
    tbl.push_back(mk(0, 8'h08, 0, 8'h08, 1, 0));
    tbl.push_back(mk(0, 8'h08, 0, 8'h08, 1, 0));
    tbl.push_back(mk(0, 8'h08, 0, 8'h00, 0, 1));
    tbl.push_back(mk(0, 8'h0C, 0, 8'h04, 1, 0));
    tbl.push_back(mk(0, 8'h0C, 1, 8'h00, 0, 0));
    tbl.push_back(mk(0, 8'hFF, 0, 8'h08, 1, 0));
    tbl.push_back(mk(0, 8'hFF, 1, 8'h00, 0, 0));
    tbl.push_back(mk(0, 8'hFF, 0, 8'h10, 1, 0));
    tbl.push_back(mk(0, 8'hFF, 1, 8'h00, 0, 0));
    tbl.push_back(mk(0, 8'h00, 1, 8'h00, 0, 0));
    tbl.push_back(mk(0, 8'h02, 0, 8'h02, 1, 0));
    tbl.push_back(mk(0, 8'h00, 0, 8'h02, 1, 0));
    tbl.push_back(mk(1, 8'h00, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 8'h03, 0, 8'h01, 1, 0));
    tbl.push_back(mk(0, 8'h03, 1, 8'h00, 0, 0));

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].q, tbl[i].d);
      cmp($sformatf("vec%0d gnt", i), int'(gnt_a), int'(tbl[i].eg));
      cmp($sformatf("vec%0d valid", i), int'(val_a), int'(tbl[i].ev));
      cmp($sformatf("vec%0d timeout", i), int'(to_a), int'(tbl[i].et));
      if (tbl[i].ev) cmp($sformatf("vec%0d idx", i), int'(idx_a), oh_idx(tbl[i].eg));
    end

    // Full rotation from reset: 0..7,0 with a dead cycle between grants.
    step(1, 8'h00, 0);
    for (int n = 0; n < 9; n++) begin
      step(0, 8'hFF, 0);
      cmp($sformatf("rot%0d idx", n), int'(idx_a), n % 8);
      cmp($sformatf("rot%0d valid", n), int'(val_a), 1);
      step(0, 8'hFF, 1);
      cmp($sformatf("rot%0d dead", n), int'(val_a), 0);
    end

    // done coincident with hold limit on the MAX_HOLD=3 instance.
    step(1, 8'h00, 0);
    step(0, 8'h10, 0);
    step(0, 8'h10, 0);
    step(0, 8'h10, 0);
    cmp("coinc held", int'(gnt_b), 32'h10);
    step(0, 8'h10, 1);
    cmp("coinc valid", int'(val_b), 0);
    cmp("coinc timeout", int'(to_b), 0);
    step(0, 8'h10, 0);
    cmp("regrant idx", int'(idx_b), 4);
    step(0, 8'h10, 0);
    step(0, 8'h10, 0);
    step(0, 8'h00, 0);
    cmp("forced valid", int'(val_b), 0);
    cmp("forced timeout", int'(to_b), 1);
    step(0, 8'h00, 0);
    cmp("timeout pulse", int'(to_b), 0);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic       r;
      logic [7:0] q;
      logic       d;
      r = ($urandom_range(0, 99) == 0);
      q = ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'($urandom);
      d = ($urandom_range(0, 4) == 0);
      step(r, q, d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Eight-requester round-robin arbiter that shares one downstream resource (a bus slot, register-file port or similar datapath unit) among eight clients. It grants one client at a time, holds the grant until the client signals completion or a hold timeout expires, and rotates priority so that no client starves. The grant is presented both one-hot and as a 3-bit binary index, so it can drive either select lines or an encoded mux select.

## Interface
- MAX_HOLD, 16: maximum grant length in cycles; 0 disables the timeout; legal range 0..255
- clk  input  1  single clock; all logic is rising-edge
- rst  input  1  synchronous, active-high reset
- req  input  8  request vector; bit i = client i requests
- done  input  1  granted client releases the resource; sampled only while gnt_valid=1
- gnt  output  8  one-hot grant; all zeros when idle
- gnt_idx  output  3  binary index of the granted client; 3'bzzz when gnt_valid=0
- gnt_valid  output  1  high while a grant is held
- timeout  output  1  one-cycle pulse on a forced release

## Operation
- There are two states: IDLE and GRANT. All outputs are registered except gnt_idx, which decodes from the registered grant.
- Reset values: state=IDLE, ptr=0, hold_cnt=0, gnt=8'h00, gnt_valid=0, timeout=0, gnt_idx=3'bzzz.
- IDLE behaviour:
  - req==0: stay in IDLE.
  - Otherwise, select the first set bit of req scanning ptr, ptr+1, … ptr+7 (mod 8).
  - Load gnt with that one-hot bit, set gnt_valid=1, hold_cnt=1, and go to GRANT.
- GRANT behaviour:
  - req is ignored; deasserting the granted bit does not release the grant.
  - done=1 releases the grant.
  - With MAX_HOLD≠0, hold_cnt==MAX_HOLD with done=0 forces a release and sets timeout=1 for the next cycle only.
  - If done=1 and hold_cnt==MAX_HOLD occur together, the release is normal and timeout stays 0.
  - Otherwise hold_cnt increments; it is 8 bits wide and saturates at 255 when MAX_HOLD=0.
- Release:
  - Next cycle: gnt=0, gnt_valid=0, state=IDLE, hold_cnt=0.
  - ptr = granted index + 1 mod 8, so 7 wraps to 0.
- Priority rotation: the client just served becomes the lowest priority. With all eight clients requesting continuously, grants go 0,1,2,…,7,0.
- done sampled in IDLE is ignored.
- rst has priority over every other event, including mid-GRANT. At the next edge all state returns to the reset values and the grant drops without a timeout pulse.

## Timing
- Request to grant: req seen at edge t produces gnt_valid=1 after edge t (1-cycle latency).
- Release:
  - done high at edge t+k gives gnt_valid=0 after edge t+k.
  - There is one mandatory dead cycle in IDLE. The next grant appears at the earliest after edge t+k+1.
  - Minimum grant period is 2 cycles per client.
- Timeout:
  - The grant lasts exactly MAX_HOLD cycles with gnt_valid=1.
  - timeout is high in the first IDLE cycle, coincident with gnt_valid=0.
- Invariants checked every cycle:
  - gnt is zero or one-hot.
  - gnt_valid == |gnt.
  - gnt_idx == log2(gnt) when gnt_valid=1.
  - timeout is never high two cycles in a row.

## Test plan
- Reset then idle: rst=1 for 2 cycles, req=0 for 5 cycles. Required: gnt=8'h00, gnt_valid=0, gnt_idx=zzz, timeout=0 throughout.
- Single client: req=8'h20, done pulsed on the 3rd grant cycle. Required: gnt=8'h20 and gnt_idx=3'd5 one cycle after req; release one cycle after done; ptr becomes 6. Then req=8'h21 → next grant is client 0 (index 6 and 7 are not requesting, so the scan wraps to 0).
- Full rotation: req=8'hFF held, done asserted on every grant's first cycle. Required: gnt_idx sequence 0,1,…,7,0, one grant every 2 cycles.
- Timeout: MAX_HOLD=4, req=8'h08, done=0. Required: gnt_valid high for exactly 4 cycles, then timeout=1 for 1 cycle. Next grant goes to client 3 again only if no other client requests; with req=8'h0C it goes to client 2 only after the scan wraps (ptr=4 → 4..7,0,1,2).
- Simultaneous done and timeout: MAX_HOLD=3, done on the 3rd grant cycle. Required: release with timeout=0.
- Reset mid-grant: client 1 granted, rst=1 for one cycle on the 2nd grant cycle. Required: all outputs at reset values after that edge, no timeout pulse; ptr=0, so with req=8'h03 the next grant goes to client 0.
